register_alias_table: RTL and testbench

- Parametrised architectural-to-physical register mapping table; successor to the fixed 4-entry swap mapper.
- Sits between decode and the register file: translates two source register indices per cycle.
- Applies remap ops (swap, rotate, checkpoint save/restore, multi-cycle clear) through a valid/ready handshake.

---
 rtl/register_alias_table.sv | 128 ++++++++++++
 tb/tb_register_alias_table.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_alias_table.sv
// Architectural-to-physical register alias table with swap/rotate remaps,
// one-level checkpoint and a multi-cycle clear walk behind a valid/ready op port.
module register_alias_table #(
  parameter  int unsigned NUM_REGS = 4,
  localparam int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_a_idx,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic [IDX_W-1:0] rd_a_map,
  output logic [IDX_W-1:0] rd_b_map,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [IDX_W-1:0] op_a,
  input  logic [IDX_W-1:0] op_b,
  output logic             ckpt_valid,
  output logic             busy,
  output logic             op_err
);

  localparam logic [2:0] OpSwap    = 3'd1;
  localparam logic [2:0] OpRotl    = 3'd2;
  localparam logic [2:0] OpRotr    = 3'd3;
  localparam logic [2:0] OpSave    = 3'd4;
  localparam logic [2:0] OpRestore = 3'd5;
  localparam logic [2:0] OpClear   = 3'd6;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  logic [IDX_W-1:0] map_q    [NUM_REGS];
  logic [IDX_W-1:0] map_d    [NUM_REGS];
  logic [IDX_W-1:0] shadow_q [NUM_REGS];
  logic [IDX_W-1:0] shadow_d [NUM_REGS];
  logic             ckpt_q, ckpt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             op_fire;

  assign op_ready   = (state_q == StIdle) && !reset;
  assign op_fire    = op_valid && op_ready;
  assign rd_a_map   = map_q[rd_a_idx];
  assign rd_b_map   = map_q[rd_b_idx];
  assign ckpt_valid = ckpt_q;
  assign busy       = (state_q == StClear);
  assign op_err     = err_q;

  always_comb begin
    map_d    = map_q;
    shadow_d = shadow_q;
    ckpt_d   = ckpt_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    state_d  = state_q;
    unique case (state_q)
      StIdle: begin
        if (op_fire) begin
          case (op_code)
            OpSwap: begin
              map_d[op_a] = map_q[op_b];
              map_d[op_b] = map_q[op_a];
            end
            // Index arithmetic wraps naturally since NUM_REGS is a power of 2.
            OpRotl: begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                map_d[IDX_W'(i)] = map_q[IDX_W'(i + 1)];
              end
            end
            OpRotr: begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                map_d[IDX_W'(i)] = map_q[IDX_W'(i + NUM_REGS - 1)];
              end
            end
            OpSave: begin
              shadow_d = map_q;
              ckpt_d   = 1'b1;
            end
            OpRestore: begin
              if (ckpt_q) begin
                map_d  = shadow_q;
                ckpt_d = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            OpClear: begin
              state_d = StClear;
              cnt_d   = '0;
            end
            default: ;
          endcase
        end
      end
      StClear: begin
        // One entry restored to identity per cycle; checkpoint is left alone.
        map_d[cnt_q] = cnt_q;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(NUM_REGS - 1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        map_q[IDX_W'(i)]    <= IDX_W'(i);
        shadow_q[IDX_W'(i)] <= IDX_W'(i);
      end
      ckpt_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= StIdle;
    end else begin
      map_q    <= map_d;
      shadow_q <= shadow_d;
      ckpt_q   <= ckpt_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_register_alias_table.sv
// Scoreboard bench for register_alias_table: directed vectors on 4- and 8-entry
// tables, a modelled op stream on a 16-entry table, and a per-cycle permutation check.
module tb_register_alias_table;

  localparam int OpNop = 0, OpSwap = 1, OpRotl = 2, OpRotr = 3;
  localparam int OpSave = 4, OpRestore = 5, OpClear = 6, OpRsvd = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rd_a_idx = '0, rd_b_idx = '0, op_a = '0, op_b = '0;
  logic [2:0] op_code = '0;
  logic       op_valid = 1'b0;

  logic [1:0] a4, b4;
  logic [2:0] a8, b8;
  logic [3:0] a16, b16;
  logic       rdy [3];
  logic       ck  [3];
  logic       bz  [3];
  logic       er  [3];

  always #5 clk = ~clk;

  register_alias_table #(.NUM_REGS(4)) u4 (
    .clk(clk), .reset(reset), .rd_a_idx(rd_a_idx[1:0]), .rd_b_idx(rd_b_idx[1:0]),
    .rd_a_map(a4), .rd_b_map(b4), .op_valid(op_valid), .op_ready(rdy[0]),
    .op_code(op_code), .op_a(op_a[1:0]), .op_b(op_b[1:0]), .ckpt_valid(ck[0]),
    .busy(bz[0]), .op_err(er[0])
  );

  register_alias_table #(.NUM_REGS(8)) u8 (
    .clk(clk), .reset(reset), .rd_a_idx(rd_a_idx[2:0]), .rd_b_idx(rd_b_idx[2:0]),
    .rd_a_map(a8), .rd_b_map(b8), .op_valid(op_valid), .op_ready(rdy[1]),
    .op_code(op_code), .op_a(op_a[2:0]), .op_b(op_b[2:0]), .ckpt_valid(ck[1]),
    .busy(bz[1]), .op_err(er[1])
  );

  register_alias_table #(.NUM_REGS(16)) u16 (
    .clk(clk), .reset(reset), .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx),
    .rd_a_map(a16), .rd_b_map(b16), .op_valid(op_valid), .op_ready(rdy[2]),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .ckpt_valid(ck[2]),
    .busy(bz[2]), .op_err(er[2])
  );

  // Expectation record: field 0 a-map, 1 b-map, 2 ckpt, 3 busy, 4 err, 5 ready.
  typedef struct {
    int    cyc;
    int    inst;
    int    field;
    int    val;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_out(input int inst, input int field);
    case (field)
      0: return (inst == 0) ? int'(a4) : (inst == 1) ? int'(a8) : int'(a16);
      1: return (inst == 0) ? int'(b4) : (inst == 1) ? int'(b8) : int'(b16);
      2: return int'(ck[inst]);
      3: return int'(bz[inst]);
      4: return int'(er[inst]);
      default: return int'(rdy[inst]);
    endcase
  endfunction

  // Monitor: drains expectations due this cycle and checks table permutations.
  exp_t        mon_e;
  int          mon_act;
  logic [15:0] pm;
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        mon_e   = sbq.pop_front();
        mon_act = get_out(mon_e.inst, mon_e.field);
        checks++;
        if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
          errors++;
          $display("FAIL %s: inst=%0d field=%0d got=%0d want=%0d cyc=%0d/%0d", mon_e.name,
                   mon_e.inst, mon_e.field, mon_act, mon_e.val, mon_e.cyc, cyc);
        end
      end
      if (!bz[0]) begin
        pm = '0;
        for (int i = 0; i < 4; i++) pm = pm | (16'd1 << u4.map_q[i]);
        checks++;
        if (pm !== 16'h000f) begin
          errors++;
          $display("FAIL perm4: got=%h want=000f cyc=%0d", pm, cyc);
        end
      end
      if (!bz[1]) begin
        pm = '0;
        for (int i = 0; i < 8; i++) pm = pm | (16'd1 << u8.map_q[i]);
        checks++;
        if (pm !== 16'h00ff) begin
          errors++;
          $display("FAIL perm8: got=%h want=00ff cyc=%0d", pm, cyc);
        end
      end
      if (!bz[2]) begin
        pm = '0;
        for (int i = 0; i < 16; i++) pm = pm | (16'd1 << u16.map_q[i]);
        checks++;
        if (pm !== 16'hffff) begin
          errors++;
          $display("FAIL perm16: got=%h want=ffff cyc=%0d", pm, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int inst, input int field, input int val, input string name);
    exp_t e;
    e.cyc   = cyc;
    e.inst  = inst;
    e.field = field;
    e.val   = val;
    e.name  = name;
    sbq.push_back(e);
  endtask

  task automatic look(input int inst, input int ia, input int ib, input int ea, input int eb,
                      input string name);
    rd_a_idx = 4'(ia);
    rd_b_idx = 4'(ib);
    expect_out(inst, 0, ea, name);
    expect_out(inst, 1, eb, name);
  endtask

  task automatic flags(input int inst, input int eck, input int ebz, input int eer,
                       input int erdy, input string name);
    expect_out(inst, 2, eck, name);
    expect_out(inst, 3, ebz, name);
    expect_out(inst, 4, eer, name);
    expect_out(inst, 5, erdy, name);
  endtask

  task automatic op(input int code, input int a, input int b);
    op_valid = 1'b1;
    op_code  = 3'(code);
    op_a     = 4'(a);
    op_b     = 4'(b);
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op_code  = 3'(OpNop);
  endtask

  // Reference model for the 16-entry random stream.
  int mm [16];
  int sh [16];
  int tmp [16];
  int mck, mbusy, mcnt, merr;
  int nv, code, ra, rb, ia, ib, accepted, guard, t;

  task automatic model_update();
    merr = 0;
    if (mbusy != 0) begin
      mm[mcnt] = mcnt;
      if (mcnt == 15) mbusy = 0;
      mcnt++;
    end else if (nv != 0) begin
      case (code)
        OpSwap: begin
          t      = mm[ra];
          mm[ra] = mm[rb];
          mm[rb] = t;
        end
        OpRotl: begin
          for (int i = 0; i < 16; i++) tmp[i] = mm[(i + 1) % 16];
          mm = tmp;
        end
        OpRotr: begin
          for (int i = 0; i < 16; i++) tmp[i] = mm[(i + 15) % 16];
          mm = tmp;
        end
        OpSave: begin
          sh  = mm;
          mck = 1;
        end
        OpRestore: begin
          if (mck != 0) begin
            mm  = sh;
            mck = 0;
          end else begin
            merr = 1;
          end
        end
        OpClear: begin
          mbusy = 1;
          mcnt  = 0;
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    // ---- 4-entry table: reset, swap, checkpoint, clear ----
    step(); flags(0, 0, 0, 0, 0, "ready low in reset");
    step(); reset = 1'b0; look(0, 2, 0, 2, 0, "reset lookup"); flags(0, 0, 0, 0, 1, "reset flags");
    op(OpSwap, 1, 3);
    step(); idle(); look(0, 1, 3, 3, 1, "swap 1 3");
    step(); op(OpSwap, 2, 2);
    step(); idle(); look(0, 2, 1, 2, 3, "swap self");
    step(); look(0, 0, 3, 0, 1, "swap self b");
    step(); op(OpSwap, 1, 3);
    step(); op(OpSave, 0, 0); look(0, 1, 3, 1, 3, "swap back"); flags(0, 0, 0, 0, 1, "pre save");
    step(); op(OpSwap, 0, 1); flags(0, 1, 0, 0, 1, "save ckpt");
    step(); op(OpRestore, 0, 0); look(0, 0, 1, 1, 0, "swap after save");
    step(); op(OpRestore, 0, 0); look(0, 0, 1, 0, 1, "restore map");
    flags(0, 0, 0, 0, 1, "restore flags");
    step(); idle(); look(0, 0, 1, 0, 1, "bad restore map"); flags(0, 0, 0, 1, 1, "err pulse");
    step(); flags(0, 0, 0, 0, 1, "err cleared");
    step(); op(OpSwap, 0, 3);
    step(); op(OpSave, 0, 0);
    step(); op(OpClear, 0, 0); look(0, 0, 3, 3, 0, "pre clear"); flags(0, 1, 0, 0, 1, "pre clear f");
    step(); op(OpSwap, 0, 3); look(0, 0, 3, 3, 0, "clear c1"); flags(0, 1, 1, 0, 0, "clear c1 f");
    step(); look(0, 0, 3, 0, 0, "clear c2"); flags(0, 1, 1, 0, 0, "clear c2 f");
    step(); look(0, 1, 3, 1, 0, "clear c3"); flags(0, 1, 1, 0, 0, "clear c3 f");
    step(); look(0, 2, 3, 2, 0, "clear c4"); flags(0, 1, 1, 0, 0, "clear c4 f");
    step(); op(OpRestore, 0, 0); look(0, 0, 3, 0, 3, "clear done"); flags(0, 1, 0, 0, 1, "done f");
    step(); idle(); look(0, 0, 3, 3, 0, "restore after clear");
    flags(0, 0, 0, 0, 1, "restore after clear f");
    step(); op(OpSave, 0, 0);
    step(); op(OpClear, 0, 0); flags(0, 1, 0, 0, 1, "rc start");
    step(); idle(); flags(0, 1, 1, 0, 0, "rc c1");
    step(); reset = 1'b1; flags(0, 1, 1, 0, 0, "rc c2 reset");
    step(); reset = 1'b0; look(0, 0, 3, 0, 3, "rc identity"); flags(0, 0, 0, 0, 1, "rc flags");
    step(); look(0, 1, 2, 1, 2, "rc identity b");

    // ---- 8-entry table: rotate wrap-around and reserved op ----
    step(); reset = 1'b1; idle();
    step(); reset = 1'b0; look(1, 0, 7, 0, 7, "id8"); flags(1, 0, 0, 0, 1, "id8 flags");
    op(OpRotl, 0, 0);
    step(); op(OpRotr, 0, 0); look(1, 7, 0, 0, 1, "rotl wrap");
    step(); op(OpRotr, 0, 0); look(1, 7, 0, 7, 0, "rotr back");
    step(); op(OpRsvd, 1, 2); look(1, 0, 1, 7, 0, "rotr wrap");
    step(); op(OpRotl, 0, 0); look(1, 0, 5, 7, 4, "reserved nop"); flags(1, 0, 0, 0, 1, "rsvd f");
    step(); idle(); look(1, 0, 7, 0, 7, "rotl back");

    // ---- 16-entry table: modelled op stream ----
    step(); reset = 1'b1; idle();
    step(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mm[i] = i;
      sh[i] = i;
    end
    mck = 0; mbusy = 0; mcnt = 0; merr = 0; accepted = 0; guard = 0;
    while (accepted < 1000 && guard < 20000) begin
      nv   = ($urandom_range(0, 3) != 0) ? 1 : 0;
      code = $urandom_range(0, 7);
      ra   = $urandom_range(0, 15);
      rb   = $urandom_range(0, 15);
      ia   = $urandom_range(0, 15);
      ib   = $urandom_range(0, 15);
      op_valid = nv[0];
      op_code  = 3'(code);
      op_a     = 4'(ra);
      op_b     = 4'(rb);
      look(2, ia, ib, mm[ia], mm[ib], "rand lookup");
      flags(2, mck, mbusy, merr, (mbusy != 0) ? 0 : 1, "rand flags");
      if (nv != 0 && mbusy == 0) accepted++;
      step();
      model_update();
      guard++;
    end
    idle();
    look(2, 0, 15, mm[0], mm[15], "rand final");
    step();
    for (int i = 0; i < 20 && sbq.size() > 0; i++) step();
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: got=%0d pending want=0", sbq.size());
    end
    if (guard >= 20000) begin
      errors++;
      $display("FAIL op budget: got=%0d accepted want=1000", accepted);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
